// File: rtl/icache_direct_if.sv
// Bundles the ifetch request/response and memory-controller line-fill signals of icache_direct.
// The cache uses the slave view; the environment (ifetch + memctrl) uses the master view.
interface icache_direct_if #(
    parameter int LINE_BYTES = 16
);
    logic                    fetch_en;
    logic [31:0]             fetch_pc;
    logic                    fetch_done;
    logic [31:0]             fetch_instr;
    logic                    mc_en;
    logic [31:0]             mc_pc;
    logic                    mc_done;
    logic [LINE_BYTES*8-1:0] mc_data;

    modport slave (
        input  fetch_en, fetch_pc, mc_done, mc_data,
        output fetch_done, fetch_instr, mc_en, mc_pc
    );

    modport master (
        output fetch_en, fetch_pc, mc_done, mc_data,
        input  fetch_done, fetch_instr, mc_en, mc_pc
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: 1-cycle hits, whole-line fills from the memory controller.
// Define ICACHE_STAT_EN to add the hit_cnt/miss_cnt statistics outputs.
//
// state | meaning
// IDLE  | serving hits; a miss latches pc and raises mc_en
// FILL  | waiting for mc_done; rollback only marks the response as cancelled
module icache_direct #(
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback,
    icache_direct_if.slave     bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WORDS  = LINE_BYTES / 4;

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state_q, state_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [31:0]         pc_q, pc_d;
    logic                cancel_q, cancel_d;
    logic                cool_q, cool_d;
    logic                done_q, done_d;
    logic [31:0]         instr_q, instr_d;
    logic                mc_en_q, mc_en_d;
    logic [31:0]         mc_pc_q, mc_pc_d;
    logic                fill_we;
    logic                hit_ev;
    logic                miss_ev;

    logic [TAG_W-1:0]    tag_arr  [SETS];
    logic [LINE_W-1:0]   data_arr [SETS];

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;

    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                              input logic [31:0]       pc);
        logic [31:0] sel;
        logic [31:0] word;
        sel  = (pc >> 2) & 32'(WORDS - 1);
        word = '0;
        for (int i = 0; i < WORDS; i++)
            if (sel == 32'(i)) word = line[i*32 +: 32];
        return word;
    endfunction

    assign req_idx  = bus.fetch_pc[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = bus.fetch_pc[31:OFF_W+IDX_W];
    assign fill_idx = pc_q[OFF_W+IDX_W-1:OFF_W];
    assign fill_tag = pc_q[31:OFF_W+IDX_W];
    assign hit      = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        cancel_d = cancel_q;
        cool_d   = cool_q;
        done_d   = done_q;
        instr_d  = instr_q;
        mc_en_d  = mc_en_q;
        mc_pc_d  = mc_pc_q;
        fill_we  = 1'b0;
        hit_ev   = 1'b0;
        miss_ev  = 1'b0;

        if (rdy) begin
            done_d = 1'b0;
            cool_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.fetch_en && !rollback) begin
                        if (hit) begin
                            done_d  = 1'b1;
                            instr_d = pick_word(data_arr[req_idx], bus.fetch_pc);
                            hit_ev  = 1'b1;
                        end else if (!cool_q) begin
                            // cool_q keeps mc_en low for the cycle the memctrl ignores requests
                            pc_d     = bus.fetch_pc;
                            mc_en_d  = 1'b1;
                            mc_pc_d  = {bus.fetch_pc[31:OFF_W], {OFF_W{1'b0}}};
                            state_d  = FILL;
                            miss_ev  = 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (rollback) cancel_d = 1'b1;
                    if (bus.mc_done) begin
                        fill_we            = 1'b1;
                        valid_d[fill_idx]  = 1'b1;
                        mc_en_d            = 1'b0;
                        state_d            = IDLE;
                        cancel_d           = 1'b0;
                        cool_d             = 1'b1;
                        if (!cancel_q && !rollback) begin
                            done_d  = 1'b1;
                            instr_d = pick_word(bus.mc_data, pc_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            pc_q     <= '0;
            cancel_q <= 1'b0;
            cool_q   <= 1'b0;
            done_q   <= 1'b0;
            instr_q  <= '0;
            mc_en_q  <= 1'b0;
            mc_pc_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            cancel_q <= cancel_d;
            cool_q   <= cool_d;
            done_q   <= done_d;
            instr_q  <= instr_d;
            mc_en_q  <= mc_en_d;
            mc_pc_q  <= mc_pc_d;
        end
    end

    // Tag/data storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= bus.mc_data;
        end
    end

    // A response held through a stall reappears once rdy returns; rollback hides it.
    assign bus.fetch_done  = done_q & rdy & ~rollback;
    assign bus.fetch_instr = instr_q;
    assign bus.mc_en       = mc_en_q;
    assign bus.mc_pc       = mc_pc_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_ev)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_ev) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = hit_ev ^ miss_ev;
`endif
endmodule
